// File: rtl/glitch_pkg.sv
// glitch_pkg: shared FSM state encoding and counter widths for the glitch trigger sequencer
package glitch_pkg;
  localparam int FIRE_W = 16;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_DELAY   = 3'd2;
  localparam logic [2:0] S_PULSE   = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;
endpackage

// File: rtl/trig_sync.sv
// trig_sync: synchronizes the asynchronous target trigger and emits a registered 1-cycle edge event
// Ports: CLK clock, RST_N sync active-low reset, din async trigger, ev 1-cycle edge pulse
module trig_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit TRIG_RISING = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic ev
);
  localparam logic IDLE_LVL = ~TRIG_RISING;
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync <= {SYNC_STAGES{IDLE_LVL}};
      prev <= IDLE_LVL;
      ev   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
      // an edge counts only when the new level is the active one
      ev   <= (sync[SYNC_STAGES-1] != prev) && (sync[SYNC_STAGES-1] == TRIG_RISING);
    end
  end
endmodule

// File: rtl/glitch_trigger_sequencer.sv
// glitch_trigger_sequencer: waits for a target trigger, counts a delay, then issues one glitch pulse
// Ports: CLK/RST_N clock and sync active-low reset; ARM latches DELAY/WIDTH in IDLE; ABORT returns to IDLE;
//        TRIG_IN async trigger; GLITCH_OUT pulse; BUSY not-IDLE; DONE end-of-holdoff strobe; FIRE_COUNT pulses issued
module glitch_trigger_sequencer
  import glitch_pkg::*;
#(
  parameter int DELAY_W        = 32,
  parameter int WIDTH_W        = 16,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2,
  parameter bit TRIG_RISING    = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ARM,
  input  logic               ABORT,
  input  logic               TRIG_IN,
  input  logic [DELAY_W-1:0] DELAY,
  input  logic [WIDTH_W-1:0] WIDTH,
  output logic               GLITCH_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic [FIRE_W-1:0]  FIRE_COUNT
);
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  logic               trig_ev;
  logic [2:0]         state, nxt;
  logic [DELAY_W-1:0] d_lat, dcnt;
  logic [WIDTH_W-1:0] w_lat, wcnt;
  logic [HW-1:0]      hcnt;
  logic               d_end, w_end, h_end;
  trig_sync #(.SYNC_STAGES(SYNC_STAGES), .TRIG_RISING(TRIG_RISING)) u_sync (
    .CLK  (CLK),
    .RST_N(RST_N),
    .din  (TRIG_IN),
    .ev   (trig_ev)
  );
  // compare-terminated counters: dcnt never exceeds d_lat-1, so an all-ones delay cannot wrap
  assign d_end = dcnt == d_lat - DELAY_W'(1);
  assign w_end = wcnt == w_lat;
  assign h_end = hcnt == HW'(HOLDOFF_CYCLES - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = ARM ? S_ARMED : S_IDLE;
      S_ARMED:   nxt = !trig_ev ? S_ARMED : d_lat == '0 ? S_PULSE : S_DELAY;
      S_DELAY:   nxt = d_end ? S_PULSE : S_DELAY;
      S_PULSE:   nxt = w_end ? S_HOLDOFF : S_PULSE;
      S_HOLDOFF: nxt = h_end ? S_IDLE : S_HOLDOFF;
      default:   nxt = S_IDLE;
    endcase
    if (ABORT) nxt = S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      d_lat      <= '0;
      w_lat      <= '0;
      dcnt       <= '0;
      wcnt       <= '0;
      hcnt       <= '0;
      GLITCH_OUT <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      FIRE_COUNT <= '0;
    end else begin
      state      <= nxt;
      GLITCH_OUT <= nxt == S_PULSE;
      BUSY       <= nxt != S_IDLE;
      DONE       <= state == S_HOLDOFF && h_end && !ABORT;
      dcnt       <= state == S_DELAY ? dcnt + DELAY_W'(1) : '0;
      // wcnt starts at 1 so the PULSE entry cycle is counted as the first pulse cycle
      wcnt       <= state == S_PULSE ? wcnt + WIDTH_W'(1) : WIDTH_W'(1);
      hcnt       <= state == S_HOLDOFF ? hcnt + HW'(1) : '0;
      if (state == S_IDLE && nxt == S_ARMED) begin
        d_lat <= DELAY;
        w_lat <= WIDTH == '0 ? WIDTH_W'(1) : WIDTH;
      end
      if (nxt == S_PULSE && state != S_PULSE) FIRE_COUNT <= FIRE_COUNT + FIRE_W'(1);
    end
  end
endmodule

// File: tb/tb_glitch_trigger_sequencer.sv
// tb_glitch_trigger_sequencer: randomized self-checking bench against a timing-rule reference model
module tb_glitch_trigger_sequencer;
  localparam int SYNC = 3;
  localparam int H    = 20;
  logic        CLK = 1'b0;
  logic        RST_N, ARM, ABORT, TRIG_IN;
  logic [31:0] DELAY;
  logic [15:0] WIDTH;
  logic        GLITCH_OUT, BUSY, DONE;
  logic [15:0] FIRE_COUNT;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  glitch_trigger_sequencer #(
    .DELAY_W(32), .WIDTH_W(16), .HOLDOFF_CYCLES(H), .SYNC_STAGES(SYNC), .TRIG_RISING(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ARM       (ARM),
    .ABORT     (ABORT),
    .TRIG_IN   (TRIG_IN),
    .DELAY     (DELAY),
    .WIDTH     (WIDTH),
    .GLITCH_OUT(GLITCH_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FIRE_COUNT(FIRE_COUNT)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLK);
    cyc++;
  endtask
  // One armed shot; the model places the pulse at trigger + SYNC + 2 + delay, max(width,1) long,
  // with DONE/BUSY-fall exactly HOLDOFF cycles after the pulse ends.
  // x: 0 plain, 1 second edge during DELAY, 2 edge during HOLDOFF, 3 ARM during PULSE
  task automatic shot(input int d, input int w, input int x);
    int t0, wl, es, first, cnt, done_c, done_n, errs, lim;
    logic [15:0] fc0;
    fc0 = FIRE_COUNT;
    DELAY = d;
    WIDTH = 16'(w);
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    DELAY = $urandom;
    WIDTH = 16'($urandom);
    check("armed_busy", BUSY, 1);
    repeat ($urandom_range(0, 4)) tick();
    TRIG_IN = 1'b1;
    t0 = cyc;
    wl = w == 0 ? 1 : w;
    es = t0 + SYNC + 2 + d;
    first = -1; cnt = 0; done_c = -1; done_n = 0; errs = 0;
    lim = es + wl + H + 20;
    while (cyc < lim) begin
      tick();
      if (GLITCH_OUT) begin
        if (first < 0) first = cyc;
        cnt++;
      end
      if (DONE) begin
        done_n++;
        if (done_c < 0) done_c = cyc;
      end
      if (GLITCH_OUT != (cyc >= es && cyc < es + wl)) errs++;
      if (BUSY != (cyc < es + wl + H)) errs++;
      if (DONE != (cyc == es + wl + H)) errs++;
      if (cyc == t0 + 2) TRIG_IN = 1'b0;
      if (x == 1 && cyc == t0 + 6) TRIG_IN = 1'b1;
      if (x == 1 && cyc == t0 + 10) TRIG_IN = 1'b0;
      if (x == 2 && cyc == es + wl + 2) TRIG_IN = 1'b1;
      if (x == 2 && cyc == es + wl + 6) TRIG_IN = 1'b0;
      if (x == 3 && cyc == es) begin
        ARM = 1'b1;
        DELAY = 0;
        WIDTH = 16'd1;
      end
      if (x == 3 && cyc == es + 1) ARM = 1'b0;
    end
    check("pulse_start", first, es);
    check("pulse_width", cnt, wl);
    check("done_at", done_c, es + wl + H);
    check("done_count", done_n, 1);
    check("profile_errs", errs, 0);
    check("fire_count", FIRE_COUNT, 16'(fc0 + 16'd1));
  endtask
  initial begin
    int acc, es, t0;
    logic [15:0] fc0;
    RST_N = 1'b0; ARM = 1'b0; ABORT = 1'b0; TRIG_IN = 1'b0; DELAY = '0; WIDTH = '0;
    repeat (5) begin
      TRIG_IN = ~TRIG_IN;
      tick();
    end
    check("rst_glitch", GLITCH_OUT, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_fire", FIRE_COUNT, 0);
    RST_N = 1'b1;
    TRIG_IN = 1'b0;
    repeat (6) tick();
    shot(10, 3, 0);
    shot(0, 0, 0);
    shot(1, 0, 0);
    shot(12, 4, 1);
    shot(3, 2, 2);
    shot(2, 5, 3);
    // edge while IDLE must not be queued for a later ARM
    fc0 = FIRE_COUNT;
    acc = 0;
    TRIG_IN = 1'b1;
    repeat (8) begin tick(); acc += GLITCH_OUT + BUSY; end
    DELAY = 0; WIDTH = 1; ARM = 1'b1;
    tick();
    ARM = 1'b0;
    repeat (15) begin tick(); acc += GLITCH_OUT + !BUSY; end
    check("idle_edge_ignored", acc, 0);
    check("idle_edge_fire", FIRE_COUNT, fc0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    TRIG_IN = 1'b0;
    check("abort_armed_busy", BUSY, 0);
    repeat (6) tick();
    // abort in the second cycle of an 8-cycle pulse
    fc0 = FIRE_COUNT;
    DELAY = 5; WIDTH = 8; ARM = 1'b1;
    tick();
    ARM = 1'b0;
    TRIG_IN = 1'b1;
    t0 = cyc;
    es = t0 + SYNC + 2 + 5;
    while (cyc < es + 1) tick();
    check("abort_pre_glitch", GLITCH_OUT, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    TRIG_IN = 1'b0;
    check("abort_glitch", GLITCH_OUT, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_fire", FIRE_COUNT, 16'(fc0 + 16'd1));
    acc = 0;
    repeat (H + 10) begin tick(); acc += GLITCH_OUT + BUSY + DONE; end
    check("abort_quiet", acc, 0);
    // ABORT beats ARM in IDLE
    ABORT = 1'b1; ARM = 1'b1; DELAY = 0; WIDTH = 1;
    tick();
    ABORT = 1'b0; ARM = 1'b0;
    check("abort_arm_busy", BUSY, 0);
    TRIG_IN = 1'b1;
    acc = 0;
    repeat (10) begin tick(); acc += GLITCH_OUT + BUSY; end
    check("abort_arm_quiet", acc, 0);
    TRIG_IN = 1'b0;
    repeat (6) tick();
    // maximum delay must not wrap into an early pulse
    DELAY = 32'hFFFF_FFFF; WIDTH = 1; ARM = 1'b1;
    tick();
    ARM = 1'b0;
    TRIG_IN = 1'b1;
    acc = 0;
    repeat (200) begin tick(); acc += GLITCH_OUT + !BUSY; end
    check("max_delay_hold", acc, 0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    TRIG_IN = 1'b0;
    check("max_delay_abort", BUSY, 0);
    repeat (6) tick();
    // fire counter wrap
    force dut.FIRE_COUNT = 16'hFFFF;
    tick();
    release dut.FIRE_COUNT;
    tick();
    check("wrap_preload", FIRE_COUNT, 16'hFFFF);
    shot(4, 2, 0);
    check("wrap_zero", FIRE_COUNT, 0);
    for (int i = 0; i < 10; i++) begin
      int d, w, x;
      x = $urandom_range(0, 3);
      d = $urandom_range(0, 30);
      if (x == 1 && d < 10) d += 10;
      w = $urandom_range(0, 8);
      shot(d, w, x);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
